// File: rtl/cfg_reg_file.sv
// cfg_reg_file: parametrised configuration register file with per-register
// reset values, read-only mask, address range checking, a sequenced
// soft-clear sweep and per-register update strobes on exported registers.
module cfg_reg_file #(
    parameter int unsigned              WIDTH    = 8,
    parameter int unsigned              DEPTH    = 16,
    parameter int unsigned              ADDR     = 4,
    parameter int unsigned              NUM_EXP  = 4,
    parameter logic [DEPTH*WIDTH-1:0]   RST_VALS = (DEPTH*WIDTH)'(32'h2021_0000),
    parameter logic [DEPTH-1:0]         RO_MASK  = '0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        WrEn,
    input  logic                        RdEn,
    input  logic                        Clr,
    input  logic [ADDR-1:0]             Address,
    input  logic [WIDTH-1:0]            WrData,
    output logic [WIDTH-1:0]            RdData,
    output logic                        RdData_VLD,
    output logic                        Err,
    output logic                        Busy,
    output logic [NUM_EXP*WIDTH-1:0]    REGS,
    output logic [NUM_EXP-1:0]          Upd
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Index counter is one bit wider than Address so DEPTH == 2^ADDR ends cleanly.
    localparam logic [ADDR:0] LAST_IDX = (ADDR+1)'(DEPTH-1);

    state_t               state_q, state_d;
    logic [ADDR:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [WIDTH-1:0]     regs_d [DEPTH];
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [NUM_EXP-1:0]   upd_q, upd_d;

    logic                 addr_hit;
    logic                 addr_ro;
    logic [WIDTH-1:0]     addr_data;

    // Address decode: range check, read-only flag and selected storage word
    always_comb begin
        addr_hit  = 1'b0;
        addr_ro   = 1'b0;
        addr_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (Address == ADDR'(i)) begin
                addr_hit  = 1'b1;
                addr_ro   = RO_MASK[i];
                addr_data = regs_q[i];
            end
        end
    end

    // FSM state register and clear-sweep index
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: Clr starts the sweep from IDLE, sweep ends after the last index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (Clr) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FSM outputs and datapath: host access arbitration and clear writes
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        err_d     = 1'b0;
        upd_d     = '0;
        busy_d    = (state_d == CLEAR);

        case (state_q)
            IDLE: begin
                if (Clr) begin
                    err_d = WrEn | RdEn;
                end else if (WrEn && RdEn) begin
                    err_d = 1'b1;
                end else if (WrEn) begin
                    if (addr_hit && !addr_ro) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            if (Address == ADDR'(i)) begin
                                regs_d[i] = WrData;
                            end
                        end
                        for (int unsigned k = 0; k < NUM_EXP; k++) begin
                            upd_d[k] = (Address == ADDR'(k));
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (RdEn) begin
                    rd_vld_d  = 1'b1;
                    rd_data_d = addr_hit ? addr_data : '0;
                    err_d     = !addr_hit;
                end
            end
            CLEAR: begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (idx_q == (ADDR+1)'(i)) begin
                        regs_d[i] = RST_VALS[i*WIDTH +: WIDTH];
                    end
                end
                err_d = WrEn | RdEn;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase
    end

    // Storage and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RST_VALS[i*WIDTH +: WIDTH];
            end
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            upd_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            upd_q     <= upd_d;
        end
    end

    // Exported registers come straight from storage
    always_comb begin
        REGS = '0;
        for (int unsigned k = 0; k < NUM_EXP; k++) begin
            REGS[k*WIDTH +: WIDTH] = regs_q[k];
        end
    end

    assign RdData     = rd_data_q;
    assign RdData_VLD = rd_vld_q;
    assign Err        = err_q;
    assign Busy       = busy_q;
    assign Upd        = upd_q;

endmodule

// File: tb/tb_cfg_reg_file.sv
// Directed self-checking bench for cfg_reg_file (DEPTH 12, register 5 read-only).
module tb_cfg_reg_file;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 12;
    localparam int unsigned A  = 4;
    localparam int unsigned NE = 4;
    // reg11 = B1, reg5 = 5A, reg3 = 20, reg2 = 21, all others 0
    localparam logic [D*W-1:0] RV = {8'hB1, 40'h0, 8'h5A, 8'h00, 8'h20, 8'h21, 16'h0000};

    logic           CLK = 1'b0;
    logic           RST;
    logic           WrEn, RdEn, Clr;
    logic [A-1:0]   Address;
    logic [W-1:0]   WrData;
    logic [W-1:0]   RdData;
    logic           RdData_VLD, Err, Busy;
    logic [NE*W-1:0] REGS;
    logic [NE-1:0]  Upd;

    logic [7:0] exp_rst [12] = '{8'h00, 8'h00, 8'h21, 8'h20, 8'h00, 8'h5A,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB1};

    int n_checks = 0;
    int n_fail   = 0;

    cfg_reg_file #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ADDR     (A),
        .NUM_EXP  (NE),
        .RST_VALS (RV),
        .RO_MASK  (12'h020)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Clr        (Clr),
        .Address    (Address),
        .WrData     (WrData),
        .RdData     (RdData),
        .RdData_VLD (RdData_VLD),
        .Err        (Err),
        .Busy       (Busy),
        .REGS       (REGS),
        .Upd        (Upd)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_d;
        RST = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Clr = 1'b0; Address = '0; WrData = '0;
        step(); step();
        n_checks++; if (RdData !== 8'h00) begin n_fail++; $display("FAIL reset_rddata: got %h want 00", RdData); end
        n_checks++; if (RdData_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", RdData_VLD); end
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", Err); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_checks++; if (Upd !== 4'b0000) begin n_fail++; $display("FAIL reset_upd: got %b want 0000", Upd); end
        n_checks++; if (REGS !== 32'h2021_0000) begin n_fail++; $display("FAIL reset_regs: got %h want 20210000", REGS); end
        RST = 1'b1;
        step();
        for (int a = 0; a < 16; a++) begin
            Address = A'(a);
            RdEn = 1'b1;
            step();
            exp_d = (a < 12) ? exp_rst[a] : 8'h00;
            n_checks++; if (RdData !== exp_d) begin n_fail++; $display("FAIL reset_read_data a=%0d: got %h want %h", a, RdData, exp_d); end
            n_checks++; if (RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL reset_read_vld a=%0d: got %b want 1", a, RdData_VLD); end
            n_checks++; if (Err !== (a >= 12)) begin n_fail++; $display("FAIL reset_read_err a=%0d: got %b want %b", a, Err, (a >= 12)); end
        end
        RdEn = 1'b0;
        step();
        n_checks++; if (RdData_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_vld_drop: got %b want 0", RdData_VLD); end
    endtask

    task automatic test_write_upd();
        WrEn = 1'b1; Address = 4'd1; WrData = 8'hA5;
        step();
        WrEn = 1'b0;
        n_checks++; if (REGS[15:8] !== 8'hA5) begin n_fail++; $display("FAIL wr_regs1: got %h want a5", REGS[15:8]); end
        n_checks++; if (Upd !== 4'b0010) begin n_fail++; $display("FAIL wr_upd1: got %b want 0010", Upd); end
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL wr_err1: got %b want 0", Err); end
        RdEn = 1'b1; Address = 4'd1;
        step();
        RdEn = 1'b0;
        n_checks++; if (RdData !== 8'hA5) begin n_fail++; $display("FAIL wr_readback1: got %h want a5", RdData); end
        n_checks++; if (RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL wr_readback_vld: got %b want 1", RdData_VLD); end
        n_checks++; if (Upd !== 4'b0000) begin n_fail++; $display("FAIL wr_upd_pulse: got %b want 0000", Upd); end
        WrEn = 1'b1; Address = 4'd3; WrData = 8'h3E;
        step();
        n_checks++; if (Upd !== 4'b1000) begin n_fail++; $display("FAIL wr_upd3: got %b want 1000", Upd); end
        n_checks++; if (REGS[31:24] !== 8'h3E) begin n_fail++; $display("FAIL wr_regs3: got %h want 3e", REGS[31:24]); end
        Address = 4'd7; WrData = 8'h77;
        step();
        WrEn = 1'b0;
        n_checks++; if (Upd !== 4'b0000) begin n_fail++; $display("FAIL wr_upd7: got %b want 0000", Upd); end
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL wr_err7: got %b want 0", Err); end
        RdEn = 1'b1; Address = 4'd7;
        step();
        RdEn = 1'b0;
        n_checks++; if (RdData !== 8'h77) begin n_fail++; $display("FAIL wr_readback7: got %h want 77", RdData); end
    endtask

    task automatic test_errors();
        WrEn = 1'b1; Address = 4'd5; WrData = 8'h3C;
        step();
        WrEn = 1'b0;
        n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL ro_err: got %b want 1", Err); end
        n_checks++; if (Upd !== 4'b0000) begin n_fail++; $display("FAIL ro_upd: got %b want 0000", Upd); end
        step();
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL ro_err_pulse: got %b want 0", Err); end
        RdEn = 1'b1; Address = 4'd5;
        step();
        RdEn = 1'b0;
        n_checks++; if (RdData !== 8'h5A) begin n_fail++; $display("FAIL ro_readback: got %h want 5a", RdData); end
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL ro_read_err: got %b want 0", Err); end
        WrEn = 1'b1; Address = 4'd13; WrData = 8'h66;
        step();
        WrEn = 1'b0;
        n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", Err); end
        n_checks++; if (REGS !== 32'h3E21_A500) begin n_fail++; $display("FAIL oor_wr_regs: got %h want 3e21a500", REGS); end
        RdEn = 1'b1; Address = 4'd5;
        step();
        n_checks++; if (RdData !== 8'h5A) begin n_fail++; $display("FAIL oor_wr_alias5: got %h want 5a", RdData); end
        Address = 4'd9;
        step();
        n_checks++; if (RdData !== 8'h00) begin n_fail++; $display("FAIL oor_wr_alias9: got %h want 00", RdData); end
        Address = 4'd13;
        step();
        RdEn = 1'b0;
        n_checks++; if (RdData !== 8'h00) begin n_fail++; $display("FAIL oor_rd_data: got %h want 00", RdData); end
        n_checks++; if (RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL oor_rd_vld: got %b want 1", RdData_VLD); end
        n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b want 1", Err); end
    endtask

    task automatic test_simultaneous();
        RdEn = 1'b1; Address = 4'd1;
        step();
        WrEn = 1'b1; RdEn = 1'b1; Address = 4'd0; WrData = 8'hFF;
        step();
        WrEn = 1'b0; RdEn = 1'b0;
        n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL simul_err: got %b want 1", Err); end
        n_checks++; if (RdData_VLD !== 1'b0) begin n_fail++; $display("FAIL simul_vld: got %b want 0", RdData_VLD); end
        n_checks++; if (RdData !== 8'hA5) begin n_fail++; $display("FAIL simul_rdhold: got %h want a5", RdData); end
        n_checks++; if (REGS[7:0] !== 8'h00) begin n_fail++; $display("FAIL simul_reg0: got %h want 00", REGS[7:0]); end
        n_checks++; if (Upd !== 4'b0000) begin n_fail++; $display("FAIL simul_upd: got %b want 0000", Upd); end
    endtask

    task automatic test_back_to_back();
        RdEn = 1'b1; Address = 4'd2;
        step();
        n_checks++; if (RdData !== 8'h21 || RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL b2b_r2: got %h/%b want 21/1", RdData, RdData_VLD); end
        Address = 4'd3;
        step();
        n_checks++; if (RdData !== 8'h3E || RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL b2b_r3: got %h/%b want 3e/1", RdData, RdData_VLD); end
        Address = 4'd11;
        step();
        RdEn = 1'b0;
        n_checks++; if (RdData !== 8'hB1 || RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL b2b_r11: got %h/%b want b1/1", RdData, RdData_VLD); end
        step();
        n_checks++; if (RdData_VLD !== 1'b0) begin n_fail++; $display("FAIL b2b_vld_drop: got %b want 0", RdData_VLD); end
    endtask

    task automatic test_soft_clear();
        int busy_cnt;
        logic upd_seen;
        for (int a = 0; a < 12; a++) begin
            WrEn = 1'b1; Address = A'(a); WrData = 8'h55;
            step();
        end
        WrEn = 1'b0;
        n_checks++; if (REGS !== 32'h5555_5555) begin n_fail++; $display("FAIL clr_prefill: got %h want 55555555", REGS); end
        Clr = 1'b1;
        step();
        Clr = 1'b0;
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise: got %b want 1", Busy); end
        busy_cnt = 1;
        upd_seen = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 3) begin WrEn = 1'b1; Address = 4'd0; WrData = 8'hEE; end
            if (cyc == 5) Clr = 1'b1;
            if (cyc == 7) begin RdEn = 1'b1; Address = 4'd2; end
            step();
            WrEn = 1'b0; RdEn = 1'b0; Clr = 1'b0;
            if (Upd !== 4'b0000) upd_seen = 1'b1;
            if (cyc == 3) begin
                n_checks++; if (Err !== 1'b1) begin n_fail++; $display("FAIL clr_wr_err: got %b want 1", Err); end
            end
            if (cyc == 5) begin
                n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL clr_clr_err: got %b want 0", Err); end
            end
            if (cyc == 7) begin
                n_checks++; if (Err !== 1'b1 || RdData_VLD !== 1'b0) begin n_fail++; $display("FAIL clr_rd_err: got err %b vld %b want 1 0", Err, RdData_VLD); end
            end
            if (Busy !== 1'b1) break;
            busy_cnt++;
        end
        n_checks++; if (busy_cnt != 12) begin n_fail++; $display("FAIL clr_busy_len: got %0d want 12", busy_cnt); end
        n_checks++; if (upd_seen !== 1'b0) begin n_fail++; $display("FAIL clr_upd: got %b want 0", upd_seen); end
        n_checks++; if (REGS !== 32'h2021_0000) begin n_fail++; $display("FAIL clr_regs: got %h want 20210000", REGS); end
        for (int a = 0; a < 12; a++) begin
            RdEn = 1'b1; Address = A'(a);
            step();
            n_checks++; if (RdData !== exp_rst[a] || RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL clr_read a=%0d: got %h/%b want %h/1", a, RdData, RdData_VLD, exp_rst[a]); end
        end
        RdEn = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_clear();
        WrEn = 1'b1; WrData = 8'h99;
        Address = 4'd0; step();
        Address = 4'd1; step();
        Address = 4'd11; step();
        WrEn = 1'b0;
        Clr = 1'b1;
        step();
        Clr = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) step();
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL rmc_busy_pre: got %b want 1", Busy); end
        #2;
        RST = 1'b0;
        #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy: got %b want 0", Busy); end
        n_checks++; if (REGS !== 32'h2021_0000) begin n_fail++; $display("FAIL rmc_regs: got %h want 20210000", REGS); end
        #2;
        RST = 1'b1;
        step();
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rmc_busy_post: got %b want 0", Busy); end
        RdEn = 1'b1; Address = 4'd11;
        step();
        n_checks++; if (RdData !== 8'hB1 || RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL rmc_read11: got %h/%b want b1/1", RdData, RdData_VLD); end
        Address = 4'd1;
        step();
        RdEn = 1'b0;
        n_checks++; if (RdData !== 8'h00 || RdData_VLD !== 1'b1) begin n_fail++; $display("FAIL rmc_read1: got %h/%b want 00/1", RdData, RdData_VLD); end
    endtask

    initial begin
        test_reset();
        test_write_upd();
        test_errors();
        test_simultaneous();
        test_back_to_back();
        test_soft_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
